// File: rtl/grid_pkg.sv
// grid_pkg: shared cell, error and state encodings plus the direction deltas
// that the win walker steps through.
package grid_pkg;
    typedef enum logic [1:0] {EMPTY = 2'b00, X = 2'b01, O = 2'b10} cell_t;
    typedef enum logic [2:0] {
        NONE = 3'd0, GAMEOVER = 3'd1, PARSE = 3'd2, TURN = 3'd3, OCCUPIED = 3'd4
    } err_code_t;
    typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;
    // (row, col) deltas in walk order: horizontal, vertical, diagonal, anti-diagonal
    localparam int DR [4] = '{0, 1, 1, 1};
    localparam int DC [4] = '{1, 0, 1, -1};
endpackage

// File: rtl/grid_readout.sv
// grid_readout: raster counter over the board and registered cell mux for the display path.
module grid_readout #(
    parameter int N = 3,
    localparam int CW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_game,
    input  logic [N*N-1:0][1:0]   cells,
    output logic [CW-1:0]         rd_row,
    output logic [CW-1:0]         rd_col,
    output logic [1:0]            rd_cell
);
    localparam int IW = $clog2(N * N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_row <= '0;
            rd_col <= '0;
        end else if (new_game) begin
            rd_row <= '0;
            rd_col <= '0;
        end else begin
            rd_col <= (rd_col == LAST) ? '0 : rd_col + 1'b1;
            if (rd_col == LAST) rd_row <= (rd_row == LAST) ? '0 : rd_row + 1'b1;
        end
    end

    assign rd_cell = cells[IW'(int'(rd_row) * N + int'(rd_col))];
endmodule

// File: rtl/grid_game_ctrl.sv
// grid_game_ctrl: N x N, K-in-a-row two-player engine with move checking and a sequential win walker.
// Define GRID_READOUT_EN to enable the raster read-out port; otherwise rd_* are tied to zero.
module grid_game_ctrl
    import grid_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3,
    localparam int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          new_game,
    input  logic          mv_valid,
    output logic          mv_ready,
    input  logic [1:0]    mv_player,
    input  logic [CW-1:0] mv_row,
    input  logic [CW-1:0] mv_col,
    output logic          err,
    output logic [2:0]    err_code,
    output logic [1:0]    turn,
    output logic [1:0]    win,
    output logic          draw,
    output logic [CW-1:0] rd_row,
    output logic [CW-1:0] rd_col,
    output logic [1:0]    rd_cell
);
    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam int MW = $clog2(NN + 1);

    state_t state, state_n;
    logic [NN-1:0][1:0] board;
    logic [MW-1:0] moves;
    cell_t turn_q;
    err_code_t code_q, rej;
    logic [CW-1:0] mr, mc;
    logic [1:0] dir;
    logic [3:0] step;
    logic [4:0] cnt, cnt_n;
    logic bwd, fok, bok, won;
    logic take, accept, hit, i_last, done, won_n, full;
    int r, c;

    assign take = mv_valid && mv_ready && !new_game;
    assign accept = take && rej == NONE;
    assign mv_ready = state != CHECK;
    assign turn = turn_q;
    assign err_code = code_q;
    assign full = moves == MW'(NN);

    always_comb begin
        rej = NONE;
        if (state == OVER) rej = GAMEOVER;
        else if (mv_player == 2'b00 || mv_player == 2'b11 || int'(mv_row) >= N || int'(mv_col) >= N) rej = PARSE;
        else if (mv_player != turn_q) rej = TURN;
        else if (board[IW'(int'(mv_row) * N + int'(mv_col))] != EMPTY) rej = OCCUPIED;
    end

    // One cell per cycle: step cells away from the last move, forward then backward
    always_comb begin
        r = int'(mr) + (bwd ? -int'(step) : int'(step)) * DR[dir];
        c = int'(mc) + (bwd ? -int'(step) : int'(step)) * DC[dir];
        hit = (bwd ? bok : fok) && r >= 0 && r < N && c >= 0 && c < N && board[IW'(r * N + c)] == turn_q;
        cnt_n = cnt + 5'(hit);
        won_n = won || int'(cnt_n) >= K;
        i_last = int'(step) == K - 1;
        done = i_last && bwd && dir == 2'd3;
    end

    always_comb begin
        state_n = state;
        if (new_game) state_n = IDLE;
        else if (state == IDLE && accept) state_n = CHECK;
        else if (state == CHECK && done) state_n = (won_n || full) ? OVER : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            board <= '0;
            moves <= '0;
            turn_q <= X;
            win <= 2'b00;
            draw <= 1'b0;
            err <= 1'b0;
            code_q <= NONE;
            mr <= '0;
            mc <= '0;
            dir <= '0;
            step <= 4'd1;
            cnt <= 5'd1;
            bwd <= 1'b0;
            fok <= 1'b1;
            bok <= 1'b1;
            won <= 1'b0;
        end else if (new_game) begin
            board <= '0;
            moves <= '0;
            turn_q <= X;
            win <= 2'b00;
            draw <= 1'b0;
            err <= 1'b0;
            code_q <= NONE;
        end else begin
            err <= take && rej != NONE;
            if (take && rej != NONE) code_q <= rej;
            if (accept) begin
                board[IW'(int'(mv_row) * N + int'(mv_col))] <= mv_player;
                moves <= moves + 1'b1;
                mr <= mv_row;
                mc <= mv_col;
                dir <= '0;
                step <= 4'd1;
                cnt <= 5'd1;
                bwd <= 1'b0;
                fok <= 1'b1;
                bok <= 1'b1;
                won <= 1'b0;
            end
            if (state == CHECK) begin
                won <= won_n;
                cnt <= cnt_n;
                if (!hit && bwd) bok <= 1'b0;
                if (!hit && !bwd) fok <= 1'b0;
                step <= i_last ? 4'd1 : step + 1'b1;
                if (i_last) bwd <= !bwd;
                if (i_last && bwd) begin
                    dir <= dir + 1'b1;
                    cnt <= 5'd1;
                    fok <= 1'b1;
                    bok <= 1'b1;
                end
                if (done && won_n) win <= turn_q;
                else if (done && full) draw <= 1'b1;
                else if (done) turn_q <= (turn_q == X) ? O : X;
            end
        end
    end

`ifdef GRID_READOUT_EN
    grid_readout #(.N(N)) u_readout (
        .clk(clk), .reset(reset), .new_game(new_game), .cells(board),
        .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell)
    );
`else
    assign rd_row = '0;
    assign rd_col = '0;
    assign rd_cell = '0;
`endif
endmodule

// File: tb/tb_grid_game_ctrl.sv
// tb_grid_game_ctrl: two engines (3x3 K=3 and 5x5 K=4) against a line-counting reference model.
module tb_grid_game_ctrl;
    localparam int NP [2] = '{3, 5};
    localparam int KP [2] = '{3, 4};

    logic clk = 0, reset = 1, run = 0;
    logic new_game [2], mv_valid [2], mv_ready [2], err [2], draw [2];
    logic [1:0] mv_player [2], turn [2], win [2], rd_cell [2];
    logic [3:0] mv_row [2], mv_col [2];
    logic [2:0] err_code [2];
    logic [1:0] rr0, rc0;
    logic [2:0] rr1, rc1;
    int checks = 0, errors = 0;

    int bd [2][15][15];
    int mturn [2], mwin [2], mdraw [2], merr [2], mcode [2], mbusy [2], mmoves [2], mrr [2], mrc [2];
    bit mover [2], mpend [2];

    always #5 clk = ~clk;

    grid_game_ctrl #(.N(3), .K(3)) dut0 (
        .clk(clk), .reset(reset), .new_game(new_game[0]), .mv_valid(mv_valid[0]), .mv_ready(mv_ready[0]),
        .mv_player(mv_player[0]), .mv_row(mv_row[0][1:0]), .mv_col(mv_col[0][1:0]), .err(err[0]),
        .err_code(err_code[0]), .turn(turn[0]), .win(win[0]), .draw(draw[0]),
        .rd_row(rr0), .rd_col(rc0), .rd_cell(rd_cell[0])
    );
    grid_game_ctrl #(.N(5), .K(4)) dut1 (
        .clk(clk), .reset(reset), .new_game(new_game[1]), .mv_valid(mv_valid[1]), .mv_ready(mv_ready[1]),
        .mv_player(mv_player[1]), .mv_row(mv_row[1][2:0]), .mv_col(mv_col[1][2:0]), .err(err[1]),
        .err_code(err_code[1]), .turn(turn[1]), .win(win[1]), .draw(draw[1]),
        .rd_row(rr1), .rd_col(rc1), .rd_cell(rd_cell[1])
    );

    task automatic chk(string name, int u, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[u%0d]: got %0d, expected %0d at %0t", name, u, act, exp, $time);
        end
    endtask

    task automatic init(int u);
        for (int y = 0; y < 15; y++) for (int x = 0; x < 15; x++) bd[u][y][x] = 0;
        mturn[u] = 1; mwin[u] = 0; mdraw[u] = 0; merr[u] = 0; mcode[u] = 0;
        mbusy[u] = 0; mmoves[u] = 0; mrr[u] = 0; mrc[u] = 0; mover[u] = 0; mpend[u] = 0;
    endtask

    // A move wins if the longest run through it along any of the four lines reaches K
    function automatic bit wins(int u, int r, int c, int p);
        for (int d = 0; d < 4; d++) begin
            int n = 1;
            int dy = (d == 0) ? 0 : 1;
            int dx = (d == 1) ? 0 : (d == 3) ? -1 : 1;
            for (int s = -1; s <= 1; s += 2)
                for (int i = 1; i < KP[u]; i++) begin
                    int y = r + s * i * dy;
                    int x = c + s * i * dx;
                    if (y < 0 || y >= NP[u] || x < 0 || x >= NP[u] || bd[u][y][x] != p) break;
                    n++;
                end
            if (n >= KP[u]) return 1;
        end
        return 0;
    endfunction

    task automatic step(int u);
        int n = NP[u];
        int p = int'(mv_player[u]);
        int r = int'(mv_row[u]);
        int c = int'(mv_col[u]);
        int code = 0;
        if (new_game[u]) begin
            init(u);
            return;
        end
        merr[u] = 0;
        if (mrc[u] == n - 1) begin
            mrc[u] = 0;
            mrr[u] = (mrr[u] == n - 1) ? 0 : mrr[u] + 1;
        end else mrc[u]++;
        if (mbusy[u] > 0) begin
            mbusy[u]--;
            if (mbusy[u] == 0) begin
                if (mpend[u]) begin mwin[u] = mturn[u]; mover[u] = 1; end
                else if (mmoves[u] == n * n) begin mdraw[u] = 1; mover[u] = 1; end
                else mturn[u] = 3 - mturn[u];
            end
        end else if (mv_valid[u]) begin
            if (mover[u]) code = 1;
            else if (p == 0 || p == 3 || r >= n || c >= n) code = 2;
            else if (p != mturn[u]) code = 3;
            else if (bd[u][r][c] != 0) code = 4;
            if (code != 0) begin
                merr[u] = 1;
                mcode[u] = code;
            end else begin
                bd[u][r][c] = p;
                mmoves[u]++;
                mpend[u] = wins(u, r, c, p);
                mbusy[u] = 8 * (KP[u] - 1);
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin init(0); init(1); end
        else begin step(0); step(1); end
    end

    always @(negedge clk) begin
        if (run) for (int u = 0; u < 2; u++) begin
            int ar = (u == 0) ? int'(rr0) : int'(rr1);
            int ac = (u == 0) ? int'(rc0) : int'(rc1);
            chk("mv_ready", u, int'(mv_ready[u]), int'(mbusy[u] == 0));
            chk("turn", u, int'(turn[u]), mturn[u]);
            chk("win", u, int'(win[u]), mwin[u]);
            chk("draw", u, int'(draw[u]), mdraw[u]);
            chk("err", u, int'(err[u]), merr[u]);
            chk("err_code", u, int'(err_code[u]), mcode[u]);
`ifdef GRID_READOUT_EN
            chk("rd_row", u, ar, mrr[u]);
            chk("rd_col", u, ac, mrc[u]);
            chk("rd_cell", u, int'(rd_cell[u]), bd[u][mrr[u]][mrc[u]]);
`else
            chk("rd_row", u, ar, 0);
            chk("rd_col", u, ac, 0);
            chk("rd_cell", u, int'(rd_cell[u]), 0);
`endif
        end
    end

    task automatic mv(int u, int p, int r, int c);
        int t = 0;
        while (!mv_ready[u] && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("ready_timeout", u, 0, 1);
        mv_valid[u] = 1; mv_player[u] = 2'(p); mv_row[u] = 4'(r); mv_col[u] = 4'(c);
        @(negedge clk);
        mv_valid[u] = 0;
    endtask

    task automatic ng(int u);
        new_game[u] = 1;
        @(negedge clk);
        new_game[u] = 0;
    endtask

    task automatic wait_ready(int u);
        int t = 0;
        while (!mv_ready[u] && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("ready_timeout", u, 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            new_game[u] = 0; mv_valid[u] = 0; mv_player[u] = 0; mv_row[u] = 0; mv_col[u] = 0;
        end
        init(0); init(1);
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        run = 1;
        chk("rst_turn", 0, int'(turn[0]), 1);
        chk("rst_ready", 0, int'(mv_ready[0]), 1);
        chk("rst_code", 0, int'(err_code[0]), 0);
        // row-0 win for X, result lands 16 cycles after the final accept
        mv(0, 1, 0, 0); mv(0, 2, 1, 0); mv(0, 1, 0, 1); mv(0, 2, 1, 1); mv(0, 1, 0, 2);
        repeat (15) @(negedge clk);
        chk("win_before_L", 0, int'(win[0]), 0);
        chk("busy_before_L", 0, int'(mv_ready[0]), 0);
        @(negedge clk);
        chk("win_at_L", 0, int'(win[0]), 1);
        chk("ready_over", 0, int'(mv_ready[0]), 1);
        mv(0, 2, 2, 2);
        chk("over_err", 0, int'(err[0]), 1);
        chk("over_code", 0, int'(err_code[0]), 1);
        @(negedge clk);
        chk("err_pulse_end", 0, int'(err[0]), 0);
        chk("code_held", 0, int'(err_code[0]), 1);
        // rejection classes
        ng(0);
        mv(0, 2, 0, 0); chk("rej_turn", 0, int'(err_code[0]), 3); chk("rej_turn_t", 0, int'(turn[0]), 1);
        mv(0, 3, 0, 0); chk("rej_p11", 0, int'(err_code[0]), 2);
        mv(0, 1, 3, 0); chk("rej_row3", 0, int'(err_code[0]), 2);
        mv(0, 1, 0, 0); chk("acc_noerr", 0, int'(err[0]), 0);
        mv(0, 2, 0, 0); chk("rej_occ", 0, int'(err_code[0]), 4); chk("rej_occ_t", 0, int'(turn[0]), 2);
        // draw
        ng(0);
        mv(0, 1, 0, 0); mv(0, 2, 0, 1); mv(0, 1, 0, 2); mv(0, 2, 1, 1); mv(0, 1, 1, 0);
        mv(0, 2, 1, 2); mv(0, 1, 2, 1); mv(0, 2, 2, 0); mv(0, 1, 2, 2);
        wait_ready(0);
        chk("draw_set", 0, int'(draw[0]), 1);
        chk("draw_nowin", 0, int'(win[0]), 0);
        // new_game mid-CHECK together with mv_valid, then alongside a live handshake
        ng(0);
        mv(0, 1, 1, 1);
        repeat (3) @(negedge clk);
        new_game[0] = 1; mv_valid[0] = 1; mv_player[0] = 2; mv_row[0] = 0; mv_col[0] = 0;
        @(negedge clk);
        new_game[0] = 0; mv_valid[0] = 0;
        chk("ng_turn", 0, int'(turn[0]), 1);
        chk("ng_err", 0, int'(err[0]), 0);
        chk("ng_ready", 0, int'(mv_ready[0]), 1);
        new_game[0] = 1; mv_valid[0] = 1; mv_player[0] = 1; mv_row[0] = 0; mv_col[0] = 0;
        @(negedge clk);
        new_game[0] = 0; mv_valid[0] = 0;
        chk("ng_drop_err", 0, int'(err[0]), 0);
        mv(0, 1, 0, 0);
        chk("ng_drop_acc", 0, int'(err[0]), 0);
        wait_ready(0);
        chk("ng_drop_turn", 0, int'(turn[0]), 2);
`ifdef GRID_READOUT_EN
        ng(0);
        for (int k = 0; k <= 9; k++) begin
            chk("raster_row", 0, int'(rr0), (k % 9) / 3);
            chk("raster_col", 0, int'(rc0), k % 3);
            @(negedge clk);
        end
        mv(0, 1, 0, 0);
        for (int t = 0; t < 10 && (rr0 != 0 || rc0 != 0); t++) @(negedge clk);
        chk("raster_cell", 0, int'(rd_cell[0]), 1);
`endif
        // asynchronous reset in the middle of a walk
        ng(0);
        mv(0, 1, 1, 1);
        repeat (3) @(negedge clk);
        #2 reset = 1;
        @(negedge clk);
        chk("arst_ready", 0, int'(mv_ready[0]), 1);
        chk("arst_turn", 0, int'(turn[0]), 1);
        #2 reset = 0;
        @(negedge clk);
        // 5x5, K=4 anti-diagonal win, 24 cycles after the final accept
        mv(1, 1, 0, 4); mv(1, 2, 0, 0); mv(1, 1, 1, 3); mv(1, 2, 4, 4);
        mv(1, 1, 2, 2); mv(1, 2, 2, 0); mv(1, 1, 3, 1);
        repeat (23) @(negedge clk);
        chk("adiag_before_L", 1, int'(win[1]), 0);
        @(negedge clk);
        chk("adiag_win", 1, int'(win[1]), 1);
        // randomized play on both engines
        ng(0); ng(1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int u = 0; u < 2; u++) begin
                int p = $urandom_range(0, 9);
                mv_valid[u] = $urandom_range(0, 2) != 0;
                mv_player[u] = p < 6 ? 2'(mturn[u]) : p < 8 ? 2'(3 - mturn[u]) : 2'($urandom_range(0, 3));
                mv_row[u] = 4'($urandom_range(0, u == 0 ? 3 : 7));
                mv_col[u] = 4'($urandom_range(0, u == 0 ? 3 : 7));
                new_game[u] = ($urandom_range(0, 199) == 0) || (mover[u] && $urandom_range(0, 7) == 0);
            end
            if (cyc == 2000) begin
                #2 reset = 1;
                @(negedge clk);
                #2 reset = 0;
            end
            @(negedge clk);
        end
        for (int u = 0; u < 2; u++) begin mv_valid[u] = 0; new_game[u] = 0; end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/grid_game_ctrl.md
# grid_game_ctrl

Parametrised N×N, K-in-a-row two-player game engine. It is the next generation of the 3×3 tic-tac-toe core, and a single block covers four functions:
- a valid/ready move port with error classification;
- turn tracking;
- a sequential line-walking win detector with draw detection;
- an optional raster read-out port for the display driver.

It sits between the pad-level move decoder and the board display path.

## Interface
- N, default 3: board side length; legal range 3..15.
- K, default 3: run length that wins; legal range 2..N.
- CW, default $clog2(N): coordinate width; localparam, derived.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- new_game  in  1  synchronous clear pulse.
- mv_valid  in  1  move request.
- mv_ready  out  1  block can accept a move.
- mv_player  in  2  01 = X, 10 = O.
- mv_row, mv_col  in  CW  target cell.
- err  out  1  one-cycle pulse when a handshaken move is rejected.
- err_code  out  3  reason for the last rejection; held until the next rejection.
- turn  out  2  player expected next.
- win  out  2  00 = none, 01 = X won, 10 = O won.
- draw  out  1  board full with no winner.
- rd_row, rd_col  out  CW  read-out coordinate.
- rd_cell  out  2  read-out cell contents.

## Operation
- Board storage: N·N two-bit cells. Encodings: 00 empty, 01 X, 10 O. A move counter runs 0..N·N.
- Outputs at reset and after new_game: all cells 00, turn = X, win = 00, draw = 0, err = 0, err_code = NONE, rd_row = rd_col = 0, state IDLE.
- States:
  - IDLE: mv_ready = 1.
  - CHECK: mv_ready = 0.
  - OVER: mv_ready = 1; every move is rejected.
- Handshake: a move is taken on any edge where mv_valid & mv_ready.
- Rejection checks, first match wins:
  - GAMEOVER (1): state is OVER.
  - PARSE (2): mv_player is 00 or 11, or row/col ≥ N.
  - TURN (3): mv_player ≠ turn.
  - OCCUPIED (4): target cell is non-empty.
- On rejection: err pulses for one cycle, err_code is updated, the board and turn are untouched, and the state is unchanged.
- On acceptance: the cell is written, the move counter is incremented, and the state moves to CHECK.
- CHECK walks four directions in order: (0,+1), (+1,0), (+1,+1), (+1,−1).
  - Per direction, run count starts at 1.
  - Forward steps i = 1..K−1, then backward steps i = 1..K−1, one cell per cycle.
  - A step increments the count only if the cell is in bounds, equals the mover, and that side's run is still unbroken.
  - The first failing step breaks that side's run.
  - Every step consumes its cycle regardless of outcome.
  - If any direction reaches count ≥ K, the move is a win.
- End of CHECK:
  - Win: win = mover, go to OVER.
  - Else if the move counter equals N·N: draw = 1, go to OVER.
  - Else: toggle turn, go to IDLE.
- new_game has priority over everything, including mid-CHECK. A handshake on the same edge as new_game is dropped silently, with no err.

## Timing
- CHECK length is L = 8(K−1) cycles; for N = K = 3, L = 16.
- Move accepted at edge E0:
  - mv_ready is low from E0 to E0+L.
  - win, draw, turn and next state are registered at edge E0+L.
  - The earliest next acceptance is edge E0+L+1.
- Board cell update is visible one cycle after E0.
- err asserts for the single cycle following the rejecting edge.
- Asserting reset mid-CHECK aborts the walk immediately to reset values.

## Configuration
- GRID_READOUT_EN defined:
  - rd_row/rd_col raster through every cell, one per cycle: col increments, wrapping to 0 and incrementing row; after (N−1, N−1) it wraps to (0,0).
  - rd_cell shows the current registered cell value.
  - new_game restarts the raster at (0,0).
- GRID_READOUT_EN undefined: rd_row, rd_col and rd_cell are tied to 0 and no raster logic is synthesised.

## Structure
- Package grid_pkg holds:
  - cell_t enum: EMPTY, X, O;
  - err_code_t enum: NONE, GAMEOVER, PARSE, TURN, OCCUPIED;
  - state_t enum: IDLE, CHECK, OVER;
  - the direction delta constants.
- Sub-module grid_readout implements the raster counter and cell mux. It is instantiated only under GRID_READOUT_EN.

## Test plan
- N = 3, K = 3, row-0 win: X(0,0), O(1,0), X(0,1), O(1,1), X(0,2), each issued when mv_ready is high. Required: win = 01 exactly 16 cycles after the last accept, state OVER. A further O(2,2) then gives err = 1, err_code = GAMEOVER.
- Rejections:
  - O moves first → TURN.
  - player 11 → PARSE.
  - row 3 → PARSE.
  - repeat of (0,0) → OCCUPIED.
  - In every case turn is unchanged and the board is unchanged.
- Draw: X(0,0), O(0,1), X(0,2), O(1,1), X(1,0), O(1,2), X(2,1), O(2,0), X(2,2). Required: draw = 1, win = 00.
- N = 5, K = 4, anti-diagonal win: X at (0,4), (1,3), (2,2), (3,1), with O elsewhere off that line. Required: win = 01, 24 cycles after the final accept.
- new_game asserted mid-CHECK together with mv_valid. Required: all reset values next cycle, no err, and the move is dropped.
- With GRID_READOUT_EN, N = 3: rd coordinates sequence (0,0)…(2,2),(0,0) with period 9. rd_cell = 01 at (0,0) after X(0,0) is accepted.
